// File: rtl/dm_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter_if
// Brief    : Bundle of load-request/response, store-commit and DM macro
//            signals shared between the port arbiter and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_port_arbiter_if #(
  parameter int SB_DEPTH = 4
);
  // Load issue / response
  logic                        ld_req_valid;
  logic                        ld_req_ready;
  logic [31:0]                 ld_req_addr;
  logic [1:0]                  ld_req_tag;
  logic                        ld_resp_valid;
  logic [1:0]                  ld_resp_tag;
  logic [31:0]                 ld_resp_data;
  // Store commit
  logic                        st_valid;
  logic                        st_ready;
  logic [31:0]                 st_addr;
  logic [31:0]                 st_data;
  logic [31:0]                 st_bmask;
  // DM macro
  logic [31:0]                 DM_rd_data;
  logic                        DM_c_en;
  logic                        DM_r_en;
  logic [31:0]                 DM_w_en;
  logic [31:0]                 DM_addr;
  logic [31:0]                 DM_w_data;
  // Status
  logic [$clog2(SB_DEPTH):0]   sb_count;

  // Requester / memory side of the bundle
  modport master (
    output ld_req_valid, ld_req_addr, ld_req_tag,
    output st_valid, st_addr, st_data, st_bmask,
    output DM_rd_data,
    input  ld_req_ready, ld_resp_valid, ld_resp_tag, ld_resp_data,
    input  st_ready,
    input  DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data,
    input  sb_count
  );

  // Arbiter side of the bundle
  modport slave (
    input  ld_req_valid, ld_req_addr, ld_req_tag,
    input  st_valid, st_addr, st_data, st_bmask,
    input  DM_rd_data,
    output ld_req_ready, ld_resp_valid, ld_resp_tag, ld_resp_data,
    output st_ready,
    output DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data,
    output sb_count
  );
endinterface
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Brief    : Shares the single-port DM between LSU loads and committed
//            stores. Stores queue in an in-order store buffer and drain when
//            the port is free, when the buffer is full, when loads have
//            starved the drain, or when a load aliases a buffered store.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
  parameter int SB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input wire logic       clk,
  input wire logic       rst,   // asynchronous, active-low
  dm_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(SB_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_READ  = 2'd1,
    PORT_WRITE = 2'd2
  } port_op_t;

  logic [31:0]         sb_addr [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [31:0]         sb_mask [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [SW-1:0]       starve_cnt;
  logic                resp_valid;
  logic [1:0]          resp_tag;

  port_op_t op;
  logic     st_ready;
  logic     push;
  logic     pop;
  logic     hit;
  logic     sb_nonempty;
  logic     sb_full;

  // Byte offsets never take part in aliasing; hits are word-granular.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, bus.ld_req_addr[1:0], bus.st_addr[1:0]};

  assign sb_nonempty = (count != '0);
  assign sb_full     = (count == FULL_CNT);
  // Held off during reset so nothing is accepted while the buffer is cleared.
  assign st_ready    = rst && !sb_full;
  assign push        = bus.st_valid && st_ready;
  assign pop         = (op == PORT_WRITE);

  // Word-address alias between the load and any buffered or arriving store.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && (sb_addr[i][31:2] == bus.ld_req_addr[31:2])) hit = 1'b1;
    end
    if (push && (bus.st_addr[31:2] == bus.ld_req_addr[31:2])) hit = 1'b1;
    hit = hit && bus.ld_req_valid;
  end

  // Per-cycle port decision: drains take priority whenever they are forced.
  always_comb begin
    op = PORT_IDLE;
    if (!rst) begin
      op = PORT_IDLE;
    end else if (sb_nonempty && (sb_full || (starve_cnt == STARVE_MAX) || hit || !bus.ld_req_valid)) begin
      op = PORT_WRITE;
    end else if (bus.ld_req_valid && !hit) begin
      op = PORT_READ;
    end
  end

  // DM macro controls follow the decision in the same cycle.
  always_comb begin
    bus.DM_c_en   = 1'b1;
    bus.DM_r_en   = 1'b0;
    bus.DM_w_en   = '1;
    bus.DM_addr   = '0;
    bus.DM_w_data = '0;
    case (op)
      PORT_WRITE: begin
        bus.DM_c_en   = 1'b0;
        bus.DM_addr   = sb_addr[head];
        bus.DM_w_data = sb_data[head];
        bus.DM_w_en   = ~sb_mask[head];
      end
      PORT_READ: begin
        bus.DM_c_en = 1'b0;
        bus.DM_r_en = 1'b1;
        bus.DM_addr = bus.ld_req_addr;
      end
      default: ;
    endcase
  end

  // Store buffer payload; contents are qualified by sb_valid so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= bus.st_addr;
      sb_data[tail] <= bus.st_data;
      sb_mask[tail] <= bus.st_bmask;
    end
  end

  // Buffer pointers, occupancy, starvation counter and load response state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      sb_valid   <= '0;
      starve_cnt <= '0;
      resp_valid <= 1'b0;
      resp_tag   <= 2'd0;
    end else begin
      if (pop) begin
        sb_valid[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      if (push) begin
        sb_valid[tail] <= 1'b1;
        tail           <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (op == PORT_WRITE) begin
        starve_cnt <= '0;
      end else if (op == PORT_READ) begin
        if (!sb_nonempty)               starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
      end

      resp_valid <= (op == PORT_READ);
      if (op == PORT_READ) resp_tag <= bus.ld_req_tag;
    end
  end

  assign bus.ld_req_ready  = (op == PORT_READ);
  assign bus.st_ready      = st_ready;
  assign bus.sb_count      = count;
  assign bus.ld_resp_valid = resp_valid;
  assign bus.ld_resp_tag   = resp_tag;
  assign bus.ld_resp_data  = bus.DM_rd_data;
endmodule
`default_nettype wire
